alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_pkg.sv | 25 ++
 rtl/nbit_ALU.sv | 59 +++++
 rtl/alu_arbiter.sv | 109 ++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared constants for the arbitrated ALU slice.
//   N, MW       : default operand/result width and opcode width
//   ALU_MODE_W  : width of the Mode port on the legacy nbit_ALU
//   OP_*        : opcode encoding driven on mode0/mode1
//   ST_*        : FSM state encoding used by alu_arbiter
package alu_pkg;

  localparam int N          = 4;
  localparam int MW         = 3;
  localparam int ALU_MODE_W = 4;

  localparam logic [MW-1:0] OP_ADD   = 3'b000;
  localparam logic [MW-1:0] OP_SUB   = 3'b001;
  localparam logic [MW-1:0] OP_AND   = 3'b010;
  localparam logic [MW-1:0] OP_OR    = 3'b011;
  localparam logic [MW-1:0] OP_XOR   = 3'b100;
  localparam logic [MW-1:0] OP_NOT_A = 3'b101;
  localparam logic [MW-1:0] OP_INC   = 3'b110;
  localparam logic [MW-1:0] OP_DEC   = 3'b111;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_EXEC = 2'b01;
  localparam logic [1:0] ST_RESP = 2'b10;

endpackage

// File: rtl/nbit_ALU.sv
// nbit_ALU: combinational N-bit ALU.
//   A, B    : operands
//   Mode    : opcode, zero-extended by callers; unused encodings give 0
//   CBin    : carry-in (ADD) or borrow-in (SUB)
//   Result  : N-bit result, INC/DEC wrap modulo 2^N
//   CBout   : carry-out (ADD) or borrow-out (SUB), 0 for all other ops
module nbit_ALU #(
  parameter int N = alu_pkg::N
) (
  input  logic [N-1:0]                  A,
  input  logic [N-1:0]                  B,
  input  logic [alu_pkg::ALU_MODE_W-1:0] Mode,
  input  logic                          CBin,
  output logic [N-1:0]                  Result,
  output logic                          CBout
);
  import alu_pkg::*;

  localparam logic [ALU_MODE_W-1:0] M_ADD   = ALU_MODE_W'(OP_ADD);
  localparam logic [ALU_MODE_W-1:0] M_SUB   = ALU_MODE_W'(OP_SUB);
  localparam logic [ALU_MODE_W-1:0] M_AND   = ALU_MODE_W'(OP_AND);
  localparam logic [ALU_MODE_W-1:0] M_OR    = ALU_MODE_W'(OP_OR);
  localparam logic [ALU_MODE_W-1:0] M_XOR   = ALU_MODE_W'(OP_XOR);
  localparam logic [ALU_MODE_W-1:0] M_NOT_A = ALU_MODE_W'(OP_NOT_A);
  localparam logic [ALU_MODE_W-1:0] M_INC   = ALU_MODE_W'(OP_INC);
  localparam logic [ALU_MODE_W-1:0] M_DEC   = ALU_MODE_W'(OP_DEC);

  // One extra bit so the carry/borrow falls out of the top of the sum.
  logic [N:0] wide;

  always_comb begin
    // NOTE: every output gets a default first so no path through the case
    // leaves a variable unassigned, which would infer a latch.
    Result = '0;
    CBout  = 1'b0;
    wide   = '0;
    case (Mode)
      M_ADD: begin
        wide   = {1'b0, A} + {1'b0, B} + (N+1)'(CBin);
        Result = wide[N-1:0];
        CBout  = wide[N];
      end
      M_SUB: begin
        // Two's-complement wrap sets the top bit exactly when A < B + CBin.
        wide   = {1'b0, A} - {1'b0, B} - (N+1)'(CBin);
        Result = wide[N-1:0];
        CBout  = wide[N];
      end
      M_AND:   Result = A & B;
      M_OR:    Result = A | B;
      M_XOR:   Result = A ^ B;
      M_NOT_A: Result = ~A;
      M_INC:   Result = A + N'(1);
      M_DEC:   Result = A - N'(1);
      default: Result = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters share one ALU through a round-robin arbiter.
// A request seen in IDLE is granted, its operands captured, computed in
// EXEC and answered in RESP with a one-cycle ack (fixed 2-cycle latency).
//   clk, nrst          : clock, synchronous active-low reset
//   req0/1             : operation requests
//   a0/b0, a1/b1       : operands per requester
//   mode0/1, cbin0/1   : opcode and carry/borrow-in per requester
//   ack0/1             : one-cycle completion pulse to the granted requester
//   result, cb_out     : registered ALU outputs
//   res_valid, res_id  : result valid strobe and owning requester
//   busy               : high whenever the FSM is not IDLE
module alu_arbiter #(
  parameter int N  = alu_pkg::N,
  parameter int MW = alu_pkg::MW
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          req0,
  input  logic          req1,
  input  logic [N-1:0]  a0,
  input  logic [N-1:0]  b0,
  input  logic [N-1:0]  a1,
  input  logic [N-1:0]  b1,
  input  logic [MW-1:0] mode0,
  input  logic [MW-1:0] mode1,
  input  logic          cbin0,
  input  logic          cbin1,
  output logic          ack0,
  output logic          ack1,
  output logic [N-1:0]  result,
  output logic          cb_out,
  output logic          res_valid,
  output logic          res_id,
  output logic          busy
);
  import alu_pkg::*;

  logic [1:0]    state;
  logic          last_served;
  logic [N-1:0]  op_a;
  logic [N-1:0]  op_b;
  logic [MW-1:0] op_mode;
  logic          op_cbin;

  logic          gnt_any;
  logic          gnt_id;
  logic [N-1:0]  alu_y;
  logic          alu_cb;

  // On a tie the requester not served last wins; a lone request always wins.
  assign gnt_any = req0 | req1;
  assign gnt_id  = (req0 && req1) ? ~last_served : req1;

  nbit_ALU #(.N(N)) u_alu (
    .A      (op_a),
    .B      (op_b),
    .Mode   (ALU_MODE_W'(op_mode)),
    .CBin   (op_cbin),
    .Result (alu_y),
    .CBout  (alu_cb)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state       <= ST_IDLE;
      last_served <= 1'b1;
      // NOTE: operand registers are reset as well, so an aborted operation
      // leaves nothing stale behind.
      op_a        <= '0;
      op_b        <= '0;
      op_mode     <= '0;
      op_cbin     <= 1'b0;
      result      <= '0;
      cb_out      <= 1'b0;
      res_id      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (gnt_any) begin
            last_served <= gnt_id;
            op_a        <= gnt_id ? a1    : a0;
            op_b        <= gnt_id ? b1    : b0;
            op_mode     <= gnt_id ? mode1 : mode0;
            op_cbin     <= gnt_id ? cbin1 : cbin0;
            state       <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          // last_served holds the current owner until the next grant.
          result <= alu_y;
          cb_out <= alu_cb;
          res_id <= last_served;
          state  <= ST_RESP;
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // res_id only changes on the EXEC edge, so the acks are one-hot in RESP.
  assign res_valid = (state == ST_RESP);
  assign ack0      = res_valid & ~res_id;
  assign ack1      = res_valid &  res_id;
  assign busy      = (state != ST_IDLE);

endmodule
